fpu_pipe: RTL and testbench

- Parametrised, pipelined floating-point arithmetic unit for the filter datapath; successor to the fixed 16-bit float helpers in the shared utility package.
- Executes ADD, SUB and MULT on a configurable sign/exponent/mantissa format with valid/ready flow control.
- Carries a channel tag alongside each operation so several filter lanes can share one unit.

---
 rtl/fpu_pipe.sv | 210 +++++++++++++++++++++
 tb/tb_fpu_pipe.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/fpu_pipe.sv
// fpu_pipe: 3-stage pipelined ADD/SUB/MULT on a {sign, exp, mantis} float format with a pass-through tag.
// Define FPU_ROUND_NEAREST_EN for round-to-nearest-even; the default build truncates toward zero.
module fpu_pipe #(
    parameter int EXP_W  = 5,
    parameter int MANT_W = 10,
    parameter int TAG_W  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [1:0]            in_op,
    input  logic [EXP_W+MANT_W:0] in_a,
    input  logic [EXP_W+MANT_W:0] in_b,
    input  logic [TAG_W-1:0]      in_tag,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [EXP_W+MANT_W:0] out_res,
    output logic [TAG_W-1:0]      out_tag
);
    localparam int FW  = 1 + EXP_W + MANT_W;
    localparam int XW  = MANT_W + 3;          // mantissa + guard, round, sticky
    localparam int SW  = XW + 1;              // add/sub result including carry
    localparam int WM  = 2 * MANT_W + 4;      // common magnitude width for both paths
    localparam int LZW = $clog2(WM) + 1;
    localparam int IEW = EXP_W + LZW + 3;     // internal exponent, wide enough for any intermediate

    localparam logic signed [IEW-1:0] EMAX = IEW'(2 ** (EXP_W - 1) - 1);
    localparam logic signed [IEW-1:0] EMIN = IEW'(-(2 ** (EXP_W - 1)));

    typedef enum logic [1:0] {
        OP_ADD = 2'd0,
        OP_MUL = 2'd1,
        OP_SUB = 2'd2,
        OP_RSV = 2'd3
    } op_e;

    function automatic logic [LZW-1:0] lzc(input logic [WM-1:0] v);
        logic [LZW-1:0] n;
        n = '0;
        for (int i = 0; i < WM; i++) begin
            if (v[i]) n = LZW'(WM - 1 - i);
        end
        return n;
    endfunction

    logic adv;
    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    // ---------------- S1: decode, pre-normalise, compare, multiply ----------------
    logic                  a_s, b_s, a_big, is_mul;
    logic [MANT_W-1:0]     a_m, b_m, a_n, b_n;
    logic signed [IEW-1:0] a_e, b_e, a_x, b_x;
    logic [LZW-1:0]        a_lz, b_lz;

    // NOTE: combinational blocks use blocking '=' and assign every output first, so no latch is inferred.
    always_comb begin
        is_mul = (op_e'(in_op) == OP_MUL);
        a_s    = in_a[FW-1];
        b_s    = in_b[FW-1] ^ (op_e'(in_op) == OP_SUB);
        a_m    = in_a[MANT_W-1:0];
        b_m    = in_b[MANT_W-1:0];
        a_e    = IEW'($signed(in_a[MANT_W +: EXP_W]));
        b_e    = IEW'($signed(in_b[MANT_W +: EXP_W]));
        a_lz   = lzc({a_m, {(WM-MANT_W){1'b0}}});
        b_lz   = lzc({b_m, {(WM-MANT_W){1'b0}}});
        a_n    = a_m << a_lz;
        b_n    = b_m << b_lz;
        a_x    = a_e - IEW'(a_lz);
        b_x    = b_e - IEW'(b_lz);
        a_big  = (a_m != '0) &&
                 ((b_m == '0) || (a_x > b_x) || ((a_x == b_x) && (a_n >= b_n)));
    end

    logic                  s1_v, s1_mul, s1_sub, s1_sign;
    logic [TAG_W-1:0]      s1_tag;
    logic signed [IEW-1:0] s1_exp;
    logic [IEW-1:0]        s1_diff;
    logic [MANT_W-1:0]     s1_big, s1_small;
    logic [2*MANT_W-1:0]   s1_prod;

    // NOTE: data registers are reset along with the valid bits; it is cheap here and keeps out_res defined.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_v     <= 1'b0;
            s1_tag   <= '0;
            s1_mul   <= 1'b0;
            s1_sub   <= 1'b0;
            s1_sign  <= 1'b0;
            s1_exp   <= '0;
            s1_diff  <= '0;
            s1_big   <= '0;
            s1_small <= '0;
            s1_prod  <= '0;
        end else if (adv) begin
            s1_v     <= in_valid;
            s1_tag   <= in_tag;
            s1_mul   <= is_mul;
            s1_sub   <= a_s ^ b_s;
            s1_sign  <= (is_mul || a_big) ? (is_mul ? (a_s ^ b_s) : a_s) : b_s;
            s1_exp   <= is_mul ? (a_e + b_e) : (a_big ? a_x : b_x);
            s1_diff  <= (a_m == '0 || b_m == '0) ? '0 : (a_big ? a_x - b_x : b_x - a_x);
            s1_big   <= a_big ? a_n : b_n;
            s1_small <= a_big ? b_n : a_n;
            s1_prod  <= {{MANT_W{1'b0}}, a_m} * {{MANT_W{1'b0}}, b_m};
        end
    end

    // ---------------- S2: align, add/subtract, leading-one detect ----------------
    logic [XW-1:0]         ext_sm, al_sm, lost_mask;
    logic [SW-1:0]         sum;
    logic [WM-1:0]         mag;
    logic signed [IEW-1:0] mag_exp;

    always_comb begin
        ext_sm    = {s1_small, 3'b000};
        lost_mask = ~({XW{1'b1}} << s1_diff);
        if (s1_diff > IEW'(MANT_W + 2)) begin
            al_sm = {{(XW-1){1'b0}}, |s1_small};
        end else begin
            al_sm = (ext_sm >> s1_diff) | {{(XW-1){1'b0}}, |(ext_sm & lost_mask)};
        end
        sum = s1_sub ? ({1'b0, s1_big, 3'b000} - {1'b0, al_sm})
                     : ({1'b0, s1_big, 3'b000} + {1'b0, al_sm});
        // Both paths land in one magnitude where value = mag * 2^(mag_exp - WM).
        if (s1_mul) begin
            mag     = {s1_prod, 4'b0000};
            mag_exp = s1_exp;
        end else begin
            mag     = {sum, {(WM-SW){1'b0}}};
            mag_exp = s1_exp + IEW'(1);
        end
    end

    logic                  s2_v, s2_sign;
    logic [TAG_W-1:0]      s2_tag;
    logic [WM-1:0]         s2_mag;
    logic signed [IEW-1:0] s2_exp;
    logic [LZW-1:0]        s2_lz;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_v    <= 1'b0;
            s2_tag  <= '0;
            s2_sign <= 1'b0;
            s2_mag  <= '0;
            s2_exp  <= '0;
            s2_lz   <= '0;
        end else if (adv) begin
            s2_v    <= s1_v;
            s2_tag  <= s1_tag;
            s2_sign <= s1_sign;
            s2_mag  <= mag;
            s2_exp  <= mag_exp;
            s2_lz   <= lzc(mag);
        end
    end

    // ---------------- S3: normalise, round, saturate/flush ----------------
    logic signed [IEW-1:0] exp_n, exp_f;
    logic [MANT_W-1:0]     mant_f;
    logic [FW-1:0]         res;
`ifdef FPU_ROUND_NEAREST_EN
    logic [WM-1:0]         norm;
    logic [MANT_W-1:0]     mant_n;
    logic [MANT_W:0]       mant_r;
    logic                  rnd_up;
`endif

    always_comb begin
        exp_n = s2_exp - IEW'(s2_lz);
`ifdef FPU_ROUND_NEAREST_EN
        norm   = s2_mag << s2_lz;
        mant_n = norm[WM-1 -: MANT_W];
        rnd_up = norm[WM-MANT_W-1] & ((|norm[WM-MANT_W-2:0]) | mant_n[0]);
        mant_r = {1'b0, mant_n} + {{MANT_W{1'b0}}, rnd_up};
        if (mant_r[MANT_W]) begin
            mant_f = {1'b1, {(MANT_W-1){1'b0}}};
            exp_f  = exp_n + IEW'(1);
        end else begin
            mant_f = mant_r[MANT_W-1:0];
            exp_f  = exp_n;
        end
`else
        mant_f = MANT_W'((s2_mag << s2_lz) >> (WM - MANT_W));
        exp_f  = exp_n;
`endif
        if (s2_mag == '0 || exp_f < EMIN) begin
            res = '0;
        end else if (exp_f > EMAX) begin
            res = {s2_sign, EMAX[EXP_W-1:0], {MANT_W{1'b1}}};
        end else begin
            res = {s2_sign, exp_f[EXP_W-1:0], mant_f};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_res   <= '0;
            out_tag   <= '0;
        end else if (adv) begin
            out_valid <= s2_v;
            out_res   <= res;
            out_tag   <= s2_tag;
        end
    end

endmodule

// File: tb/tb_fpu_pipe.sv
// Scoreboard bench for fpu_pipe: directed vectors push expectations, a monitor pops on each output handshake.
module tb_fpu_pipe;
    localparam int EXP_W  = 5;
    localparam int MANT_W = 10;
    localparam int TAG_W  = 4;
    localparam int FW     = 1 + EXP_W + MANT_W;

    localparam logic [1:0] ADD = 2'd0, MUL = 2'd1, SUB = 2'd2, RSV = 2'd3;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid, in_ready, out_valid, out_ready;
    logic [1:0]        in_op;
    logic [FW-1:0]     in_a, in_b, out_res;
    logic [TAG_W-1:0]  in_tag, out_tag;

    fpu_pipe #(.EXP_W(EXP_W), .MANT_W(MANT_W), .TAG_W(TAG_W)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_res(out_res), .out_tag(out_tag)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [FW-1:0]    res;
        logic [TAG_W-1:0] tag;
        int               cyc;
        bit               chk;
        int               id;
    } exp_t;

    exp_t sbq[$];
    int   tests = 0;
    int   fails = 0;
    int   n_id = 0;
    bit   saw_stall = 1'b0;

    function automatic logic [FW-1:0] fp(input logic s, input int e, input logic [MANT_W-1:0] m);
        logic [EXP_W-1:0] ef;
        ef = EXP_W'(e);
        return {s, ef, m};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    task automatic issue(input logic [1:0] op, input logic [FW-1:0] a, input logic [FW-1:0] b,
                         input logic [TAG_W-1:0] tag, input logic [FW-1:0] res, input bit chk);
        exp_t e;
        int   waited;
        waited = 0;
        @(negedge clk);
        in_valid = 1'b1;
        in_op    = op;
        in_a     = a;
        in_b     = b;
        in_tag   = tag;
        #1;
        while (!in_ready && waited < 200) begin
            @(negedge clk);
            #1;
            waited++;
        end
        if (!in_ready) begin
            check($sformatf("accept_timeout%0d", n_id), 32'(in_ready), 32'd1);
        end else begin
            e.res = res;
            e.tag = tag;
            e.cyc = cyc;
            e.chk = chk;
            e.id  = n_id;
            sbq.push_back(e);
        end
        n_id++;
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while (sbq.size() != 0 && n < 200) begin
            @(posedge clk);
            n++;
        end
        check(name, 32'(sbq.size()), 32'd0);
    endtask

    // Monitor: a handshake is committed at the next rising edge when both valid and ready are high.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (out_valid && !out_ready) begin
                saw_stall = 1'b1;
                check("in_ready_during_stall", 32'(in_ready), 32'd0);
            end
            if (out_valid && out_ready) begin
                if (sbq.size() == 0) begin
                    check("unexpected_output_tag", 32'(out_tag), 32'hFFFF_FFFF);
                end else begin
                    e = sbq.pop_front();
                    check($sformatf("res%0d", e.id), 32'(out_res), 32'(e.res));
                    check($sformatf("tag%0d", e.id), 32'(out_tag), 32'(e.tag));
                    if (e.chk) check($sformatf("latency%0d", e.id), 32'(cyc - e.cyc), 32'd3);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d pending", sbq.size());
        $fatal(1, "watchdog");
    end

    logic [FW-1:0] r_round, r_sticky;

    initial begin
`ifdef FPU_ROUND_NEAREST_EN
        r_round  = fp(0, 2, 10'h300);
        r_sticky = fp(0, 0, 10'h200);
`else
        r_round  = fp(0, 2, 10'h2FF);
        r_sticky = fp(0, -1, 10'h3FF);
`endif
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_op     = '0;
        in_a      = '0;
        in_b      = '0;
        in_tag    = '0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_res", 32'(out_res), 32'd0);
        check("rst_out_tag", 32'(out_tag), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1 check("in_ready_after_rst", 32'(in_ready), 32'd1);

        // Directed vectors, back to back, downstream always ready.
        issue(ADD, fp(0, 1, 10'h300), fp(0, 1, 10'h200), 4'd1,  fp(0, 2, 10'h280), 1'b1);
        issue(MUL, fp(0, 1, 10'h300), fp(0, 1, 10'h300), 4'd2,  fp(0, 2, 10'h240), 1'b1);
        issue(SUB, fp(0, 1, 10'h300), fp(0, 1, 10'h300), 4'd3,  '0,                1'b1);
        issue(MUL, fp(1, 15, 10'h200), fp(0, 15, 10'h200), 4'd4, fp(1, 15, 10'h3FF), 1'b1);
        issue(MUL, fp(0, -16, 10'h200), fp(0, -16, 10'h200), 4'd5, '0,             1'b1);
        issue(ADD, fp(0, 1, 10'h3FF), fp(0, 1, 10'h200), 4'd6,  r_round,           1'b1);
        issue(SUB, fp(0, 1, 10'h200), fp(0, 1, 10'h300), 4'd7,  fp(1, 0, 10'h200), 1'b1);
        issue(ADD, fp(0, 3, 10'h280), '0,                4'd8,  fp(0, 3, 10'h280), 1'b1);
        issue(MUL, fp(0, 3, 10'h280), '0,                4'd9,  '0,                1'b1);
        issue(RSV, fp(0, 1, 10'h300), fp(0, 1, 10'h200), 4'd10, fp(0, 2, 10'h280), 1'b1);
        issue(ADD, fp(0, 1, 10'h100), fp(0, 0, 10'h200), 4'd11, fp(0, 1, 10'h200), 1'b1);
        issue(ADD, fp(0, 15, 10'h300), fp(0, 15, 10'h300), 4'd12, fp(0, 15, 10'h3FF), 1'b1);
        issue(ADD, fp(0, 5, 10'h200), fp(1, 0, 10'h200), 4'd13, fp(0, 4, 10'h3E0), 1'b1);
        issue(SUB, fp(0, 0, 10'h200), fp(0, -16, 10'h200), 4'd14, r_sticky,        1'b1);
        wait_drain("drain_directed");

        // Backpressure: six ops, tags 0..5, with out_ready held low for 4 cycles mid-stream.
        fork
            begin
                for (int i = 0; i < 6; i++) begin
                    if (i % 2 == 0)
                        issue(ADD, fp(0, i, 10'h200), fp(0, i, 10'h200), TAG_W'(i),
                              fp(0, i + 1, 10'h200), 1'b0);
                    else
                        issue(MUL, fp(0, 1, 10'h200), fp(0, i, 10'h300), TAG_W'(i),
                              fp(0, i, 10'h300), 1'b0);
                end
            end
            begin
                repeat (4) @(posedge clk);
                #1 out_ready = 1'b0;
                repeat (4) @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        wait_drain("drain_backpressure");
        check("stall_observed", 32'(saw_stall), 32'd1);

        // Reset with three operations in flight and the output stalled.
        @(posedge clk);
        #1 out_ready = 1'b0;
        issue(ADD, fp(0, 1, 10'h300), fp(0, 1, 10'h200), 4'd1, fp(0, 2, 10'h280), 1'b0);
        issue(ADD, fp(0, 1, 10'h300), fp(0, 1, 10'h200), 4'd2, fp(0, 2, 10'h280), 1'b0);
        issue(ADD, fp(0, 1, 10'h300), fp(0, 1, 10'h200), 4'd3, fp(0, 2, 10'h280), 1'b0);
        check("pre_rst_out_valid", 32'(out_valid), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("async_rst_out_valid", 32'(out_valid), 32'd0);
        check("async_rst_out_res", 32'(out_res), 32'd0);
        check("async_rst_out_tag", 32'(out_tag), 32'd0);
        sbq.delete();
        out_ready = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (6) @(posedge clk);
        issue(MUL, fp(0, 1, 10'h300), fp(0, 1, 10'h300), 4'd9, fp(0, 2, 10'h240), 1'b1);
        wait_drain("drain_after_rst");
        repeat (4) @(posedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
